// File: rtl/avalon_dma_sequencer_if.sv
// Avalon initiator command/response bundle plus cipher-core start/done handshake.
// master: sequencer side (issues bus commands, launches the core, supplies the block).
// slave:  interconnect/core side (returns read data, waitrequest and the core result).
//
// Ports (all carried as interface signals):
//   avm_read/avm_write/avm_address/avm_writedata  sequencer -> interconnect
//   avm_readdata/avm_waitrequest                  interconnect -> sequencer
//   core_start/core_din                           sequencer -> cipher core
//   core_done/core_dout                           cipher core -> sequencer
interface avalon_dma_sequencer_if #(
    parameter int BLK_WORDS = 4
);
    logic                     avm_read;
    logic                     avm_write;
    logic [31:0]              avm_address;
    logic [31:0]              avm_writedata;
    logic [31:0]              avm_readdata;
    logic                     avm_waitrequest;
    logic                     core_start;
    logic [32*BLK_WORDS-1:0]  core_din;
    logic                     core_done;
    logic [32*BLK_WORDS-1:0]  core_dout;

    modport master (
        output avm_read,
        output avm_write,
        output avm_address,
        output avm_writedata,
        input  avm_readdata,
        input  avm_waitrequest,
        output core_start,
        output core_din,
        input  core_done,
        input  core_dout
    );

    modport slave (
        input  avm_read,
        input  avm_write,
        input  avm_address,
        input  avm_writedata,
        output avm_readdata,
        output avm_waitrequest,
        input  core_start,
        input  core_din,
        output core_done,
        output core_dout
    );
endinterface

// File: rtl/avalon_dma_sequencer.sv
// avalon_dma_sequencer: moves num_blk cipher blocks memory -> cipher core -> memory over one Avalon initiator.
// Latency: per block BLK_WORDS reads + 1 core-start cycle + L core cycles + BLK_WORDS writes; done one cycle after the last write.
// Backpressure: avm_waitrequest freezes the FSM with the current command (strobe, address, data) held; the core is never stalled.
//
// Ports:
//   clk, reset                      rising-edge clock, asynchronous active-high reset
//   start, src_addr, dest_addr,     job request from the register file; sampled only in IDLE
//   num_blk
//   busy, done                      busy outside IDLE/FINISH; done is a one-cycle completion pulse
//   irq, irq_clear                  completion interrupt and its acknowledge
//   bus                             Avalon initiator + cipher-core handshake (master modport)
//
// Build option: define AVALON_DMA_SEQ_IRQ_EN for a sticky irq (set by done, cleared by irq_clear,
// set wins on a tie). Without it irq is tied low and irq_clear is ignored.
module avalon_dma_sequencer #(
    parameter int BLK_WORDS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [31:0]            src_addr,
    input  logic [31:0]            dest_addr,
    input  logic [31:0]            num_blk,
    output logic                   busy,
    output logic                   done,
    output logic                   irq,
    input  logic                   irq_clear,
    avalon_dma_sequencer_if.master bus
);
    localparam int          BW        = 32 * BLK_WORDS;
    localparam logic [3:0]  LAST_IDX  = 4'(BLK_WORDS - 1);
    localparam logic [31:0] BLK_BYTES = 32'(4 * BLK_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CSTART,
        S_CWAIT,
        S_WRITE,
        S_FINISH
    } state_t;

    state_t state;
    state_t state_nxt;

    // Job context, latched at start so later register-file changes are invisible.
    logic [31:0]   src_q;
    logic [31:0]   dest_q;
    logic [31:0]   rem_q;
    logic [3:0]    idx_q;
    logic [BW-1:0] din_q;
    logic [BW-1:0] res_q;

    logic          rd_cmd;
    logic          wr_cmd;
    logic [31:0]   addr_cmd;
    logic [31:0]   wdat_cmd;
    logic          cstart_cmd;
    logic [31:0]   res_word;
    logic [31:0]   word_off;
    logic          last_word;
    logic          rd_acc;
    logic          wr_acc;

    assign word_off  = {26'd0, idx_q, 2'b00};
    assign last_word = (idx_q == LAST_IDX);
    assign rd_acc    = (state == S_READ)  && !bus.avm_waitrequest;
    assign wr_acc    = (state == S_WRITE) && !bus.avm_waitrequest;

    // Result word selected by the write index.
    always_comb begin
        res_word = '0;
        for (int i = 0; i < BLK_WORDS; i++) begin
            if (idx_q == 4'(i)) begin
                res_word = res_q[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Commands are decoded purely from registered state, so they cannot move
    // while waitrequest is high and they drop to zero the moment reset asserts.
    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        done       = 1'b0;
        rd_cmd     = 1'b0;
        wr_cmd     = 1'b0;
        addr_cmd   = '0;
        wdat_cmd   = '0;
        cstart_cmd = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (num_blk == 32'd0) ? S_FINISH : S_READ;
                end
            end
            S_READ: begin
                busy     = 1'b1;
                rd_cmd   = 1'b1;
                addr_cmd = src_q + word_off;
                if (rd_acc && last_word) begin
                    state_nxt = S_CSTART;
                end
            end
            S_CSTART: begin
                busy       = 1'b1;
                cstart_cmd = 1'b1;
                state_nxt  = S_CWAIT;
            end
            S_CWAIT: begin
                busy = 1'b1;
                if (bus.core_done) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                busy     = 1'b1;
                wr_cmd   = 1'b1;
                addr_cmd = dest_q + word_off;
                wdat_cmd = res_word;
                if (wr_acc && last_word) begin
                    // rem_q still holds the count including the block just written.
                    state_nxt = (rem_q == 32'd1) ? S_FINISH : S_READ;
                end
            end
            S_FINISH: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q  <= '0;
            dest_q <= '0;
            rem_q  <= '0;
            idx_q  <= '0;
            din_q  <= '0;
            res_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && (num_blk != 32'd0)) begin
                        src_q  <= src_addr;
                        dest_q <= dest_addr;
                        rem_q  <= num_blk;
                        idx_q  <= '0;
                    end
                end
                S_READ: begin
                    if (rd_acc) begin
                        for (int i = 0; i < BLK_WORDS; i++) begin
                            if (idx_q == 4'(i)) begin
                                din_q[32*i +: 32] <= bus.avm_readdata;
                            end
                        end
                        idx_q <= last_word ? 4'd0 : idx_q + 4'd1;
                    end
                end
                S_CWAIT: begin
                    if (bus.core_done) begin
                        res_q <= bus.core_dout;
                        idx_q <= '0;
                    end
                end
                S_WRITE: begin
                    if (wr_acc) begin
                        if (last_word) begin
                            // Address arithmetic wraps modulo 2^32 by construction.
                            idx_q  <= '0;
                            src_q  <= src_q + BLK_BYTES;
                            dest_q <= dest_q + BLK_BYTES;
                            rem_q  <= rem_q - 32'd1;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.avm_read      = rd_cmd;
    assign bus.avm_write     = wr_cmd;
    assign bus.avm_address   = addr_cmd;
    assign bus.avm_writedata = wdat_cmd;
    assign bus.core_start    = cstart_cmd;
    // din_q is only written by READ captures, so it stays put from core_start
    // until the next block's first read is accepted.
    assign bus.core_din      = din_q;

`ifdef AVALON_DMA_SEQ_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else if (done) begin
            irq_q <= 1'b1;
        end else if (irq_clear) begin
            irq_q <= 1'b0;
        end
    end

    // OR-ing done in makes irq visible in the same cycle as the done pulse.
    assign irq = irq_q | done;
`else
    logic unused_irq_clear;

    assign unused_irq_clear = irq_clear;
    assign irq              = 1'b0;
`endif

endmodule
